ale_topk: RTL and testbench
===========================

Name: ale_topk

Overview:
Parametrised atmospheric light estimator that replaces the single-maximum dark-channel tracker with top-K candidate averaging.
- Per 3x3 RGB window: computes per-channel minima, then the dark channel. Keeps the TOPK windows with the largest dark channel in a sorted register list.
- At end of frame: averages the per-channel minima of those candidates to produce A_R/A_G/A_B, then computes Q0.16 reciprocals with a sequential divider.
- Sits between the 3x3 window generator and the transmission/recovery stages; results hold stable for use by the next frame.

Parameters:
DATA_W, 8, bits per colour channel
IMG_W, 512, pixels per line
IMG_H, 512, lines per frame; IMG_W*IMG_H >= TOPK
TOPK, 4, candidate count; power of two, 1..16
A_LOW, 100, lower clamp for A (used only with ALE_A_CLAMP_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
frame_start  in  1  single-cycle pulse; clears list/counter and begins a new frame
in_valid  in  1  window valid
in_ready  out  1  high only in ACCUM; a window is accepted on in_valid&&in_ready
in_window  in  27*DATA_W  9 pixels x 3 channels; pixel p, channel c at [(p*3+c)*DATA_W +: DATA_W]; c=0 B, 1 G, 2 R
A_R, A_G, A_B  out  DATA_W each  atmospheric light
Inv_A_R, Inv_A_G, Inv_A_B  out  16 each  min(floor(65536/A), 65535); 65535 when A=0
done  out  1  level; high while results for the last completed frame are valid
busy  out  1  high in DRAIN/AVG/DIV

Behaviour:
- Reset (async):
  - all outputs 0 except in_ready=1.
  - state ACCUM; list entries invalid; pixel counter 0.
- Stage 1 (registered): per-channel min of 9 values, plus valid.
- Stage 2 (registered): dark = min(R,G,B).
  - Candidate inserts into the descending-sorted list when its dark > dark of the last entry, or the last entry is invalid.
  - Insertion shifts lower entries down one slot; the last entry is discarded.
  - Ties keep older entries. Invalid entries rank below any value.
- Pixel counter counts accepted windows. On acceptance of window IMG_W*IMG_H-1: ACCUM -> DRAIN and in_ready falls next cycle.
- FSM:
  - ACCUM: exits as above.
  - DRAIN: 2 cycles, flushes the pipeline.
  - AVG: 1 cycle.
    - Sums each channel over TOPK entries, sum width DATA_W+log2(TOPK).
    - Right shift by log2(TOPK), truncating.
  - DIV: 17 cycles.
    - Three parallel restoring dividers, dividend 2^16 (17 bits), divisor A.
    - Quotient saturates to 65535; A=0 forces 65535.
  - DONE: A_*, Inv_A_*, done update on the same edge.
- Latency: done rises on edge t+21, where t is the edge accepting the last window.
- In DONE:
  - in_ready=0; outputs hold.
  - frame_start -> ACCUM: done=0, list cleared, counter 0. A_*/Inv_A_* keep the previous frame's values until the next DONE.
- frame_start in ACCUM: restarts the frame (list and counter cleared). Windows already in stage 1/2 are discarded.
- frame_start in DRAIN/AVG/DIV: ignored.
- frame_start coincident with accepted in_valid: that window is the first window of the new frame.
- in_valid while in_ready=0: ignored; no counting.
- rst mid-frame or mid-divide: immediate return to reset values; no partial results reach the outputs.

Optional Feature:
ALE_A_CLAMP_EN
- Defined: after AVG, each channel of A is clamped to [A_LOW, 2^DATA_W-1] before division. Inv then never exceeds floor(65536/A_LOW). Adds no cycles.
- Undefined: A is the raw average, A_LOW is unused, and A=0 yields Inv 65535.

Test Plan:
- IMG 4x4, TOPK=4; all windows uniform RGB (200,150,100) -> done at t+21; A=(200,150,100); Inv=(327,436,655).
- 4x4; 16 windows with dark values 1..16, R=G=B=dark -> list {16,15,14,13}; A=(14,14,14) (58/4 truncated); Inv=4681.
- 4x4; two windows tie at max dark=50 with R=50 vs R=90 (G=B=50) -> both held, arrival order preserved; averages match the model.
- All-zero frame -> A=0, Inv=65535. With ALE_A_CLAMP_EN -> A=100, Inv=655.
- Mid-frame frame_start after 7 windows, then full 16-window frame -> result reflects only the new frame. rst asserted during DIV -> all outputs 0, in_ready=1.
- in_valid held high through DRAIN/DIV/DONE -> no windows counted. frame_start in DONE with coincident in_valid -> that window counted as #0. Prior A remains until new done.

Source files
------------

// File: rtl/ale_topk.sv
// ale_topk: atmospheric light estimator using top-K dark-channel candidates.
//
// Each accepted 3x3 RGB window is reduced to per-channel minima and a dark
// channel value. The TOPK windows with the largest dark channel are kept in a
// descending-sorted register list. At end of frame, the per-channel minima of
// those candidates are averaged into A_R/A_G/A_B. Sequential dividers then
// produce Q0.16 reciprocals. Results hold until the next frame completes.
//
// Optional feature macro: ALE_A_CLAMP_EN. When defined, each averaged channel
// is clamped to [A_LOW, 2^DATA_W-1] before division.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   frame_start          pulse: clear list and counter, start a new frame
//   in_valid/in_ready    window handshake; in_ready is high only while accumulating
//   in_window            9 pixels x 3 channels; pixel p, channel c (0 B, 1 G, 2 R)
//                        at [(p*3+c)*DATA_W +: DATA_W]
//   A_R, A_G, A_B        atmospheric light per channel
//   Inv_A_R/G/B          min(floor(65536/A), 65535); 65535 when A = 0
//   done                 results of the last completed frame are valid
//   busy                 draining, averaging or dividing
module ale_topk #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned TOPK   = 4,
  parameter int unsigned A_LOW  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [27*DATA_W-1:0]  in_window,
  output logic [DATA_W-1:0]     A_R,
  output logic [DATA_W-1:0]     A_G,
  output logic [DATA_W-1:0]     A_B,
  output logic [15:0]           Inv_A_R,
  output logic [15:0]           Inv_A_G,
  output logic [15:0]           Inv_A_B,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned NPIX      = IMG_W * IMG_H;
  localparam int unsigned CNT_W     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned LG        = $clog2(TOPK);
  localparam int unsigned SUM_W     = DATA_W + LG;
  localparam int unsigned SEQ_W     = 5;
  localparam int unsigned DRAIN_CYC = 2;
  localparam int unsigned DIV_STEPS = 17;

  typedef enum logic [2:0] {S_ACCUM, S_DRAIN, S_AVG, S_DIV, S_DONE} state_t;

  // Channel-indexed triple: [0] B, [1] G, [2] R.
  typedef logic [2:0][DATA_W-1:0] rgb_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dark;
    rgb_t              ch;
  } cand_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] cnt_q, cnt_base;
  logic             accept, restart, last_hit;

  logic             s1_vld;
  rgb_t             s1_min, win_min;
  cand_t            s2_q;
  logic [DATA_W-1:0] dark_c;

  cand_t            list_q   [TOPK];
  cand_t            list_d   [TOPK];
  cand_t            shifted  [TOPK];
  logic [TOPK:0]    gtx;

  logic [2:0][SUM_W-1:0]  sum;
  rgb_t                   a_next, a_q;
  logic [2:0][DATA_W:0]   rem_q, rem_d, rem_sh;
  logic [2:0][16:0]       quo_q, quo_d;
  logic [2:0][15:0]       inv_c;
  logic                   step_bit;

  // Next-state, handshake and pixel-count control.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    restart = 1'b0;
    case (state_q)
      S_ACCUM: begin
        restart = frame_start;
        accept  = in_valid;
      end
      S_DRAIN: if (seq_q == SEQ_W'(DRAIN_CYC - 1)) state_d = S_AVG;
      S_AVG:   state_d = S_DIV;
      S_DIV:   if (seq_q == SEQ_W'(DIV_STEPS)) state_d = S_DONE;
      S_DONE: begin
        // A restart from DONE also takes a coincident window as window 0.
        if (frame_start) begin
          restart = 1'b1;
          accept  = in_valid;
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
    cnt_base = restart ? '0 : cnt_q;
    last_hit = accept && (cnt_base == CNT_W'(NPIX - 1));
    if (last_hit) state_d = S_DRAIN;
    seq_d = (state_d != state_q) ? '0 : seq_q + SEQ_W'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACCUM;
      seq_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      if (last_hit)    cnt_q <= '0;
      else if (accept) cnt_q <= cnt_base + CNT_W'(1);
      else             cnt_q <= cnt_base;
    end
  end

  // Per-channel minimum over the nine pixels.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      win_min[c] = in_window[c*DATA_W +: DATA_W];
      for (int p = 1; p < 9; p++) begin
        if (in_window[(p*3+c)*DATA_W +: DATA_W] < win_min[c])
          win_min[c] = in_window[(p*3+c)*DATA_W +: DATA_W];
      end
    end
  end

  // Dark channel of the stage-1 minima.
  always_comb begin
    dark_c = s1_min[0];
    if (s1_min[1] < dark_c) dark_c = s1_min[1];
    if (s1_min[2] < dark_c) dark_c = s1_min[2];
  end

  // Sorted insertion: gtx[i+1] marks entries the candidate outranks. The list
  // is sorted with invalid entries last, so gtx is a run of 0s then 1s; the
  // first 1 takes the candidate and the rest shift down one slot.
  always_comb begin
    gtx[0] = 1'b0;
    for (int i = 0; i < TOPK; i++)
      gtx[i+1] = !list_q[i].vld || (s2_q.dark > list_q[i].dark);
    shifted[0] = s2_q;
    for (int i = 1; i < TOPK; i++)
      shifted[i] = list_q[i-1];
    for (int i = 0; i < TOPK; i++) begin
      list_d[i] = list_q[i];
      if (s2_q.vld && gtx[i+1])
        list_d[i] = gtx[i] ? shifted[i] : s2_q;
    end
  end

  // Pipeline stages and candidate list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_min <= '0;
      s2_q   <= '0;
      list_q <= '{default: '0};
    end else begin
      s1_vld <= accept;
      s1_min <= win_min;
      if (restart) begin
        s2_q   <= '0;
        list_q <= '{default: '0};
      end else begin
        s2_q.vld  <= s1_vld;
        s2_q.dark <= dark_c;
        s2_q.ch   <= s1_min;
        list_q    <= list_d;
      end
    end
  end

  // Per-channel average of the candidates, optionally clamped.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum[c] = '0;
      for (int i = 0; i < TOPK; i++)
        sum[c] = sum[c] + SUM_W'(list_q[i].ch[c]);
      a_next[c] = DATA_W'(sum[c] >> LG);
`ifdef ALE_A_CLAMP_EN
      if (a_next[c] < DATA_W'(A_LOW)) a_next[c] = DATA_W'(A_LOW);
`endif
    end
  end

`ifndef ALE_A_CLAMP_EN
  logic [31:0] unused_a_low;
  assign unused_a_low = 32'(A_LOW);
`endif

  // One restoring-division step per channel; the dividend 2^16 contributes a
  // single 1 bit on the first step and zeros afterwards.
  always_comb begin
    step_bit = (seq_q == '0);
    for (int c = 0; c < 3; c++) begin
      rem_sh[c] = {rem_q[c][DATA_W-1:0], step_bit};
      rem_d[c]  = rem_sh[c];
      quo_d[c]  = {quo_q[c][15:0], 1'b0};
      if (rem_sh[c] >= {1'b0, a_q[c]}) begin
        rem_d[c] = rem_sh[c] - {1'b0, a_q[c]};
        quo_d[c] = {quo_q[c][15:0], 1'b1};
      end
      inv_c[c] = ((a_q[c] == '0) || quo_q[c][16]) ? 16'hFFFF : quo_q[c][15:0];
    end
  end

  // Averaging and divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (state_q == S_AVG) begin
      a_q   <= a_next;
      rem_q <= '0;
      quo_q <= '0;
    end else if ((state_q == S_DIV) && (seq_q < SEQ_W'(DIV_STEPS))) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  // Registered outputs; results move out only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      A_R      <= '0;
      A_G      <= '0;
      A_B      <= '0;
      Inv_A_R  <= '0;
      Inv_A_G  <= '0;
      Inv_A_B  <= '0;
    end else begin
      in_ready <= (state_d == S_ACCUM);
      busy     <= (state_d == S_DRAIN) || (state_d == S_AVG) || (state_d == S_DIV);
      done     <= (state_d == S_DONE);
      if ((state_q == S_DIV) && (state_d == S_DONE)) begin
        A_B     <= a_q[0];
        A_G     <= a_q[1];
        A_R     <= a_q[2];
        Inv_A_B <= inv_c[0];
        Inv_A_G <= inv_c[1];
        Inv_A_R <= inv_c[2];
      end
    end
  end

endmodule

// File: tb/tb_ale_topk.sv
// tb_ale_topk: self-checking bench for ale_topk on a 4x4 image with TOPK=4.
// Expected results come from a reference model that keeps every window of the
// frame and selects the TOPK largest dark values (earliest first on ties).
module tb_ale_topk;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned TOPK   = 4;
  localparam int unsigned A_LOW  = 100;
  localparam int unsigned NPIX   = IMG_W * IMG_H;

  logic                  clk;
  logic                  rst;
  logic                  frame_start;
  logic                  in_valid;
  logic                  in_ready;
  logic [27*DATA_W-1:0]  in_window;
  logic [DATA_W-1:0]     A_R, A_G, A_B;
  logic [15:0]           Inv_A_R, Inv_A_G, Inv_A_B;
  logic                  done;
  logic                  busy;

  ale_topk #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .TOPK(TOPK), .A_LOW(A_LOW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_window(in_window),
    .A_R(A_R), .A_G(A_G), .A_B(A_B),
    .Inv_A_R(Inv_A_R), .Inv_A_G(Inv_A_G), .Inv_A_B(Inv_A_B),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned r;
    int unsigned g;
    int unsigned b;
  } win_t;

  win_t        frame_q[$];
  int unsigned exp_a[3];      // index 0 R, 1 G, 2 B
  int unsigned exp_inv[3];
  int unsigned held_a_r   = 0;
  int unsigned held_inv_r = 0;
  int unsigned last_edge  = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned dark_of(input win_t w);
    int unsigned d;
    d = w.r;
    if (w.g < d) d = w.g;
    if (w.b < d) d = w.b;
    return d;
  endfunction

  // Reference: pick TOPK largest dark values (earliest wins ties), average, divide.
  task automatic model_result();
    bit          used[];
    int unsigned s[3];
    int          best;
    used = new[frame_q.size()];
    s = '{0, 0, 0};
    for (int k = 0; k < TOPK; k++) begin
      best = -1;
      for (int j = 0; j < frame_q.size(); j++)
        if (!used[j] && (best < 0 || dark_of(frame_q[j]) > dark_of(frame_q[best])))
          best = j;
      used[best] = 1'b1;
      s[0] += frame_q[best].r;
      s[1] += frame_q[best].g;
      s[2] += frame_q[best].b;
    end
    for (int c = 0; c < 3; c++) begin
      exp_a[c] = s[c] / TOPK;
`ifdef ALE_A_CLAMP_EN
      if (exp_a[c] < A_LOW) exp_a[c] = A_LOW;
`endif
      if (exp_a[c] == 0) exp_inv[c] = 65535;
      else exp_inv[c] = (65536 / exp_a[c] > 65535) ? 65535 : 65536 / exp_a[c];
    end
  endtask

  // Window whose per-channel minima equal m; other pixels random above it.
  function automatic logic [27*DATA_W-1:0] make_window(input win_t m, input bit uniform);
    logic [27*DATA_W-1:0] w;
    int unsigned mv[3];
    int unsigned hold;
    mv[0] = m.b; mv[1] = m.g; mv[2] = m.r;
    w = '0;
    for (int c = 0; c < 3; c++) begin
      hold = $urandom_range(8, 0);
      for (int p = 0; p < 9; p++) begin
        if (uniform || p == hold) w[(p*3+c)*DATA_W +: DATA_W] = DATA_W'(mv[c]);
        else w[(p*3+c)*DATA_W +: DATA_W] = DATA_W'($urandom_range(255, mv[c]));
      end
    end
    return w;
  endfunction

  function automatic win_t gen(input int kind, input int i);
    win_t m;
    case (kind)
      0: m = '{r: 200, g: 150, b: 100};
      1: m = '{r: i + 1, g: i + 1, b: i + 1};
      2: begin
        if (i == 3)      m = '{r: 90, g: 50, b: 50};
        else if (i == 9) m = '{r: 50, g: 50, b: 50};
        else m = '{r: $urandom_range(255, 0), g: $urandom_range(255, 0), b: $urandom_range(49, 0)};
      end
      3: m = '{r: 0, g: 0, b: 0};
      default: m = '{r: $urandom_range(255, 0), g: $urandom_range(255, 0), b: $urandom_range(255, 0)};
    endcase
    return m;
  endfunction

  // Drive one window at the current negedge; it is taken on the next posedge.
  task automatic send(input win_t m, input bit uniform, input bit fs);
    if (fs) frame_q.delete();
    else chk("in_ready_accum", 32'(in_ready), 32'd1);
    in_window   = make_window(m, uniform);
    in_valid    = 1'b1;
    frame_start = fs;
    frame_q.push_back(m);
    @(negedge clk);
    last_edge   = cyc;
    frame_start = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic run_frame(input int kind, input int n_win, input bit hold_valid);
    bit uniform;
    uniform = (kind == 0) || (kind == 3);
    for (int i = 0; i < n_win; i++) begin
      if (i > 1 && $urandom_range(3, 0) == 0) @(negedge clk);
      send(gen(kind, i), uniform, i == 0);
      if (i == 0) begin
        chk("done_cleared", 32'(done), 32'd0);
        chk("a_r_held", 32'(A_R), held_a_r);
        chk("inv_r_held", 32'(Inv_A_R), held_inv_r);
      end
    end
    if (hold_valid) begin
      in_window = make_window(gen(4, 0), 1'b0);
      in_valid  = 1'b1;
    end
  endtask

  task automatic finish_frame();
    bit got;
    got = 1'b0;
    model_result();
    chk("in_ready_drop", 32'(in_ready), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd1);
    for (int k = 0; k < 100 && !got; k++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    chk("done_timeout", 32'(got), 32'd1);
    chk("latency", cyc - last_edge, 32'd21);
    chk("busy_done", 32'(busy), 32'd0);
    chk("a_r", 32'(A_R), exp_a[0]);
    chk("a_g", 32'(A_G), exp_a[1]);
    chk("a_b", 32'(A_B), exp_a[2]);
    chk("inv_r", 32'(Inv_A_R), exp_inv[0]);
    chk("inv_g", 32'(Inv_A_G), exp_inv[1]);
    chk("inv_b", 32'(Inv_A_B), exp_inv[2]);
    held_a_r   = exp_a[0];
    held_inv_r = exp_inv[0];
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_a"}, {8'd0, A_R, A_G, A_B}, 32'd0);
    chk({tag, "_inv_rg"}, {Inv_A_R, Inv_A_G}, 32'd0);
    chk({tag, "_inv_b"}, 32'(Inv_A_B), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_window   = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Uniform frame.
    run_frame(0, NPIX, 1'b0);
    finish_frame();
    chk("uni_a_r", 32'(A_R), 32'd200);
    chk("uni_a_g", 32'(A_G), 32'd150);
    chk("uni_a_b", 32'(A_B), 32'd100);
    chk("uni_inv", {Inv_A_R, Inv_A_G}, {16'd327, 16'd436});
    chk("uni_inv_b", 32'(Inv_A_B), 32'd655);
    chk("done_in_ready", 32'(in_ready), 32'd0);

    // Ramp 1..16: frame_start in DONE with a coincident window.
    run_frame(1, NPIX, 1'b0);
    finish_frame();
    chk("ramp_a", {8'd0, A_R, A_G, A_B}, {8'd0, 8'd14, 8'd14, 8'd14});
    chk("ramp_inv", 32'(Inv_A_G), 32'd4681);

    // Tie at the maximum dark value.
    run_frame(2, NPIX, 1'b0);
    finish_frame();

    // All-zero frame.
    run_frame(3, NPIX, 1'b0);
    finish_frame();
`ifdef ALE_A_CLAMP_EN
    chk("zero_a_clamped", 32'(A_R), 32'd100);
    chk("zero_inv_clamped", 32'(Inv_A_B), 32'd655);
`else
    chk("zero_a", 32'(A_R), 32'd0);
    chk("zero_inv", 32'(Inv_A_B), 32'd65535);
`endif

    // Restart after 7 windows, then a full frame.
    run_frame(4, 7, 1'b0);
    repeat (2) @(negedge clk);
    run_frame(4, NPIX, 1'b0);
    finish_frame();

    // in_valid held high through DRAIN/DIV/DONE.
    run_frame(4, NPIX, 1'b1);
    finish_frame();
    repeat (5) @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    run_frame(1, NPIX, 1'b0);
    finish_frame();

    // Reset during DIV.
    run_frame(4, NPIX, 1'b0);
    repeat (8) @(negedge clk);
    chk("busy_mid_div", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_state("rst_div");
    @(negedge clk);
    rst = 1'b0;
    held_a_r   = 0;
    held_inv_r = 0;
    @(negedge clk);
    chk_reset_state("post_rst");

    // A few more random frames.
    for (int f = 0; f < 3; f++) begin
      run_frame(4, NPIX, 1'b0);
      finish_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
